bpi_flash_read_phy: RTL and testbench

Physical read sequencer for the parallel BPI NOR flash, directly downstream of the flash read FSM's memory-request stream. Accepts one word address at a time and drives the flash pins (CE#, OE#, ADV#, WE#, address bus) with configurable asynchronous-read wait states. Returns the sampled DQ word together with the request acknowledge. Keeps CE#/OE# asserted across back-to-back burst addresses and, optionally, uses the shorter intra-page access time.

---
 rtl/bpi_flash_pkg.sv | 23 ++
 rtl/bpi_flash_read_phy_if.sv | 31 +++
 rtl/bpi_flash_iob_regs.sv | 61 ++++++
 rtl/bpi_flash_read_phy.sv | 160 ++++++++++++++++
 tb/tb_bpi_flash_read_phy.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bpi_flash_pkg.sv
// Shared types and sizing helpers for the BPI flash read path.
package bpi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_NEXT,
    ST_RECOVER
  } bpi_state_t;

  function automatic int bpi_addr_width(input longint mem_size, input int mem_width);
    return $clog2((8 * mem_size) / mem_width);
  endfunction

  function automatic int bpi_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int C_DEF_READ_CYCLES = 12;
  localparam int C_CNT_WIDTH       = bpi_cnt_width(C_DEF_READ_CYCLES);

endpackage

// File: rtl/bpi_flash_read_phy_if.sv
// Request/response streams and flash pins of the BPI read PHY.
interface bpi_flash_read_phy_if #(
  parameter int C_MEM_WIDTH  = 16,
  parameter int C_ADDR_WIDTH = 26
);
  logic [C_ADDR_WIDTH-1:0] s_axis_addr_tdata;
  logic                    s_axis_addr_tvalid;
  logic                    s_axis_addr_tready;
  logic [C_MEM_WIDTH-1:0]  m_axis_data_tdata;
  logic                    m_axis_data_tvalid;
  logic [C_ADDR_WIDTH-1:0] bpi_addr;
  logic [C_MEM_WIDTH-1:0]  bpi_dq_i;
  logic [C_MEM_WIDTH-1:0]  bpi_dq_t;
  logic                    bpi_ce_n;
  logic                    bpi_oe_n;
  logic                    bpi_we_n;
  logic                    bpi_adv_n;
  logic                    busy;

  modport slave (
    input  s_axis_addr_tdata, s_axis_addr_tvalid, bpi_dq_i,
    output s_axis_addr_tready, m_axis_data_tdata, m_axis_data_tvalid,
           bpi_addr, bpi_dq_t, bpi_ce_n, bpi_oe_n, bpi_we_n, bpi_adv_n, busy
  );

  modport master (
    output s_axis_addr_tdata, s_axis_addr_tvalid, bpi_dq_i,
    input  s_axis_addr_tready, m_axis_data_tdata, m_axis_data_tvalid,
           bpi_addr, bpi_dq_t, bpi_ce_n, bpi_oe_n, bpi_we_n, bpi_adv_n, busy
  );
endinterface

// File: rtl/bpi_flash_iob_regs.sv
// Pad-side registers: address and control pin drivers plus the DQ capture flop,
// kept in one module so they can be packed into the I/O blocks.
module bpi_flash_iob_regs #(
  parameter int C_MEM_WIDTH  = 16,
  parameter int C_ADDR_WIDTH = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load_addr,
  input  logic [C_ADDR_WIDTH-1:0] i_addr,
  input  logic                    i_assert,
  input  logic                    i_release,
  input  logic                    i_capture,
  input  logic [C_MEM_WIDTH-1:0]  i_dq,
  output logic [C_ADDR_WIDTH-1:0] o_addr,
  output logic                    o_ce_n,
  output logic                    o_oe_n,
  output logic                    o_adv_n,
  output logic [C_MEM_WIDTH-1:0]  o_data
);

  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic                    r_ce_n;
  logic                    r_oe_n;
  logic                    r_adv_n;
  logic [C_MEM_WIDTH-1:0]  r_data;

  // Asynchronous reset releases the flash pins without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_adv_n <= 1'b1;
      r_data  <= '0;
    end else begin
      if (i_load_addr) begin
        r_addr <= i_addr;
      end
      if (i_assert) begin
        r_ce_n  <= 1'b0;
        r_oe_n  <= 1'b0;
        r_adv_n <= 1'b0;
      end else if (i_release) begin
        r_ce_n  <= 1'b1;
        r_oe_n  <= 1'b1;
        r_adv_n <= 1'b1;
      end
      if (i_capture) begin
        r_data <= i_dq;
      end
    end
  end

  assign o_addr  = r_addr;
  assign o_ce_n  = r_ce_n;
  assign o_oe_n  = r_oe_n;
  assign o_adv_n = r_adv_n;
  assign o_data  = r_data;

endmodule

// File: rtl/bpi_flash_read_phy.sv
// Asynchronous-read sequencer for parallel BPI NOR flash with burst CE# hold.
// Define BPI_FLASH_PAGE_MODE_EN to use the shorter intra-page access time.
module bpi_flash_read_phy
  import bpi_flash_pkg::*;
#(
  parameter int C_MEM_WIDTH      = 16,
  parameter int C_ADDR_WIDTH     = 26,
  parameter int C_READ_CYCLES    = 12,
  parameter int C_PAGE_CYCLES    = 3,
  parameter int C_PAGE_WORDS     = 16,
  parameter int C_CE_HIGH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  bpi_flash_read_phy_if.slave bus
);

  localparam int C_CNT_W = bpi_cnt_width(C_READ_CYCLES);
  localparam int C_REC_W = bpi_cnt_width(C_CE_HIGH_CYCLES);

  bpi_state_t r_state;
  bpi_state_t w_next;

  logic [C_CNT_W-1:0]      r_cnt;
  logic [C_REC_W-1:0]      r_rec;
  logic                    r_valid;
  logic                    r_busy;
  logic                    w_load_addr;
  logic                    w_assert;
  logic                    w_release;
  logic                    w_capture;
  logic                    w_page_hit;
  logic [C_ADDR_WIDTH-1:0] w_addr_q;
  logic [C_MEM_WIDTH-1:0]  w_data_q;

`ifdef BPI_FLASH_PAGE_MODE_EN
  localparam int C_PAGE_BITS = $clog2(C_PAGE_WORDS);

  // Only consulted in ST_NEXT, where CE# has stayed low since the burst began.
  assign w_page_hit = (bus.s_axis_addr_tdata[C_ADDR_WIDTH-1:C_PAGE_BITS] ==
                       w_addr_q[C_ADDR_WIDTH-1:C_PAGE_BITS]);
`else
  assign w_page_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load_addr = 1'b0;
    w_assert    = 1'b0;
    w_release   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_axis_addr_tvalid) begin
          w_load_addr = 1'b1;
          w_assert    = 1'b1;
          w_next      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.s_axis_addr_tvalid) begin
          w_release = 1'b1;
          w_next    = ST_RECOVER;
        end else if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = ST_DATA;
        end
      end
      ST_DATA: begin
        w_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (bus.s_axis_addr_tvalid) begin
          w_load_addr = 1'b1;
          w_next      = ST_WAIT;
        end else begin
          w_release = 1'b1;
          w_next    = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (r_rec == '0) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_release = 1'b1;
        w_next    = ST_RECOVER;
      end
    endcase
  end

  // Wait-state and CE#-high counters; reloaded on the transition into their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_rec <= '0;
    end else begin
      if (r_state == ST_IDLE && w_load_addr) begin
        r_cnt <= C_CNT_W'(C_READ_CYCLES - 1);
      end else if (r_state == ST_NEXT && w_load_addr) begin
        r_cnt <= w_page_hit ? C_CNT_W'(C_PAGE_CYCLES - 1) : C_CNT_W'(C_READ_CYCLES - 1);
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - C_CNT_W'(1);
      end

      if (w_release) begin
        r_rec <= C_REC_W'(C_CE_HIGH_CYCLES - 1);
      end else if (r_state == ST_RECOVER && r_rec != '0) begin
        r_rec <= r_rec - C_REC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (w_next == ST_DATA);
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  bpi_flash_iob_regs #(
    .C_MEM_WIDTH  (C_MEM_WIDTH),
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_iob (
    .clk         (clk),
    .rst         (rst),
    .i_load_addr (w_load_addr),
    .i_addr      (bus.s_axis_addr_tdata),
    .i_assert    (w_assert),
    .i_release   (w_release),
    .i_capture   (w_capture),
    .i_dq        (bus.bpi_dq_i),
    .o_addr      (w_addr_q),
    .o_ce_n      (bus.bpi_ce_n),
    .o_oe_n      (bus.bpi_oe_n),
    .o_adv_n     (bus.bpi_adv_n),
    .o_data      (w_data_q)
  );

  assign bus.bpi_addr           = w_addr_q;
  assign bus.m_axis_data_tdata  = w_data_q;
  assign bus.m_axis_data_tvalid = r_valid;
  assign bus.s_axis_addr_tready = r_valid;
  assign bus.busy               = r_busy;
  assign bus.bpi_we_n           = 1'b1;
  assign bus.bpi_dq_t           = '1;

endmodule

// File: tb/tb_bpi_flash_read_phy.sv
// Directed bench for bpi_flash_read_phy: single read, bursts, page crossing,
// abort and asynchronous reset, with hand-computed cycle and data expectations.
module tb_bpi_flash_read_phy;

  localparam int C_MEM_WIDTH  = 16;
  localparam int C_ADDR_WIDTH = 26;
  localparam int C_READ       = 12;
  localparam int C_PAGE       = 3;
  localparam int MISS_GAP     = C_READ + 2;
`ifdef BPI_FLASH_PAGE_MODE_EN
  localparam int HIT_GAP = C_PAGE + 2;
`else
  localparam int HIT_GAP = C_READ + 2;
`endif

  logic clk;
  logic rst;

  int testCount;
  int failCount;

  logic [C_ADDR_WIDTH-1:0] burstAddr [3];
  int                      pulseAt   [3];
  logic [C_MEM_WIDTH-1:0]  pulseData [3];
  logic                    pulseReady[3];
  int                      pulseCount;
  bit                      ceRoseEarly;
  int                      ceRiseAt;
  int                      idleAt;

  bpi_flash_read_phy_if #(.C_MEM_WIDTH(C_MEM_WIDTH), .C_ADDR_WIDTH(C_ADDR_WIDTH)) bus ();

  bpi_flash_read_phy #(
    .C_MEM_WIDTH      (C_MEM_WIDTH),
    .C_ADDR_WIDTH     (C_ADDR_WIDTH),
    .C_READ_CYCLES    (C_READ),
    .C_PAGE_CYCLES    (C_PAGE),
    .C_PAGE_WORDS     (16),
    .C_CE_HIGH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model: word 0x100 holds 0xBEEF, every other word holds ~addr[15:0].
  assign bus.bpi_dq_i = (!bus.bpi_ce_n && !bus.bpi_oe_n) ?
                        ((bus.bpi_addr == 26'h100) ? 16'hBEEF : ~bus.bpi_addr[15:0]) :
                        16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [C_ADDR_WIDTH-1:0] addr);
    bus.s_axis_addr_tvalid = valid;
    bus.s_axis_addr_tdata  = addr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents burstAddr[0..nWords-1] back to back starting at cycle 0 and logs pulse cycles.
  task automatic runBurst(input int nWords);
    int idx;
    idx         = 0;
    ceRoseEarly = 0;
    ceRiseAt    = -1;
    idleAt      = -1;
    for (int i = 0; i < 3; i++) begin
      pulseAt[i]    = -1;
      pulseData[i]  = '0;
      pulseReady[i] = 1'b0;
    end
    applyStimulus(1'b1, burstAddr[0]);
    for (int k = 1; k <= 120 && idleAt < 0; k++) begin
      stepCycle();
      if (bus.m_axis_data_tvalid) begin
        if (idx < 3) begin
          pulseAt[idx]    = k;
          pulseData[idx]  = bus.m_axis_data_tdata;
          pulseReady[idx] = bus.s_axis_addr_tready;
        end
        idx++;
        if (idx < nWords) applyStimulus(1'b1, burstAddr[idx]);
        else applyStimulus(1'b0, '0);
      end
      if (bus.bpi_ce_n && idx < nWords) ceRoseEarly = 1;
      if (bus.bpi_ce_n && idx >= nWords && ceRiseAt < 0) ceRiseAt = k;
      if (!bus.busy && idx >= nWords && idleAt < 0) idleAt = k;
    end
    pulseCount = idx;
    applyStimulus(1'b0, '0);
    stepCycle();
  endtask

  initial begin
    int seenAt;
    bit earlyPulse;
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    repeat (3) stepCycle();

    checkOutput("rst_ce_n",   {31'd0, bus.bpi_ce_n}, 1);
    checkOutput("rst_oe_n",   {31'd0, bus.bpi_oe_n}, 1);
    checkOutput("rst_we_n",   {31'd0, bus.bpi_we_n}, 1);
    checkOutput("rst_adv_n",  {31'd0, bus.bpi_adv_n}, 1);
    checkOutput("rst_addr",   32'(bus.bpi_addr), 0);
    checkOutput("rst_dq_t",   32'(bus.bpi_dq_t), 32'hFFFF);
    checkOutput("rst_data",   32'(bus.m_axis_data_tdata), 0);
    checkOutput("rst_tvalid", {31'd0, bus.m_axis_data_tvalid}, 0);
    checkOutput("rst_tready", {31'd0, bus.s_axis_addr_tready}, 0);
    checkOutput("rst_busy",   {31'd0, bus.busy}, 0);

    rst = 1'b0;
    repeat (2) stepCycle();

    // Single read of 0x100.
    burstAddr[0] = 26'h100;
    runBurst(1);
    checkOutput("single_pulse_cycle", 32'(pulseAt[0]), 13);
    checkOutput("single_data",        32'(pulseData[0]), 32'hBEEF);
    checkOutput("single_tready",      {31'd0, pulseReady[0]}, 1);
    checkOutput("single_pulse_width", 32'(pulseCount), 1);
    checkOutput("single_ce_rise",     32'(ceRiseAt), 15);
    checkOutput("single_idle",        32'(idleAt), 17);
    checkOutput("single_we_n",        {31'd0, bus.bpi_we_n}, 1);

    // Same-page burst 0x10, 0x11, 0x12.
    burstAddr[0] = 26'h10; burstAddr[1] = 26'h11; burstAddr[2] = 26'h12;
    runBurst(3);
    checkOutput("burst_pulse0", 32'(pulseAt[0]), 13);
    checkOutput("burst_pulse1", 32'(pulseAt[1]), 32'(13 + HIT_GAP));
    checkOutput("burst_pulse2", 32'(pulseAt[2]), 32'(13 + 2 * HIT_GAP));
    checkOutput("burst_data0",  32'(pulseData[0]), 32'hFFEF);
    checkOutput("burst_data1",  32'(pulseData[1]), 32'hFFEE);
    checkOutput("burst_data2",  32'(pulseData[2]), 32'hFFED);
    checkOutput("burst_ce_held", {31'd0, ceRoseEarly}, 0);
    checkOutput("burst_idle",   32'(idleAt), 32'(13 + 2 * HIT_GAP + 4));

    // Page crossing 0x1E, 0x1F, 0x20: the last word is a full first access.
    burstAddr[0] = 26'h1E; burstAddr[1] = 26'h1F; burstAddr[2] = 26'h20;
    runBurst(3);
    checkOutput("cross_pulse1", 32'(pulseAt[1]), 32'(13 + HIT_GAP));
    checkOutput("cross_pulse2", 32'(pulseAt[2]), 32'(13 + HIT_GAP + MISS_GAP));
    checkOutput("cross_data2",  32'(pulseData[2]), 32'hFFDF);
    checkOutput("cross_ce_held", {31'd0, ceRoseEarly}, 0);

    // Abort: tvalid drops in cycle 5, new request presented from cycle 6.
    earlyPulse = 0;
    applyStimulus(1'b1, 26'h200);
    for (int k = 1; k <= 5; k++) begin
      stepCycle();
      if (bus.m_axis_data_tvalid) earlyPulse = 1;
    end
    applyStimulus(1'b0, '0);
    stepCycle();
    checkOutput("abort_ce_n_c6",  {31'd0, bus.bpi_ce_n}, 1);
    checkOutput("abort_oe_n_c6",  {31'd0, bus.bpi_oe_n}, 1);
    applyStimulus(1'b1, 26'h300);
    stepCycle();
    if (bus.m_axis_data_tvalid) earlyPulse = 1;
    checkOutput("abort_ce_n_c7",  {31'd0, bus.bpi_ce_n}, 1);
    stepCycle();
    if (bus.m_axis_data_tvalid) earlyPulse = 1;
    checkOutput("abort_ce_n_c8",  {31'd0, bus.bpi_ce_n}, 1);
    checkOutput("abort_busy_c8",  {31'd0, bus.busy}, 0);
    stepCycle();
    checkOutput("abort_ce_n_c9",  {31'd0, bus.bpi_ce_n}, 0);
    checkOutput("abort_addr_c9",  32'(bus.bpi_addr), 32'h300);
    checkOutput("abort_no_pulse", {31'd0, earlyPulse}, 0);
    seenAt = -1;
    for (int k = 10; k <= 40 && seenAt < 0; k++) begin
      stepCycle();
      if (bus.m_axis_data_tvalid) begin
        seenAt = k;
        checkOutput("abort_retry_data", 32'(bus.m_axis_data_tdata), 32'hFCFF);
        applyStimulus(1'b0, '0);
      end
    end
    checkOutput("abort_retry_cycle", 32'(seenAt), 21);
    applyStimulus(1'b0, '0);
    for (int k = 0; k < 20 && bus.busy; k++) stepCycle();
    stepCycle();

    // Asynchronous reset in cycle 6 of a read.
    applyStimulus(1'b1, 26'h100);
    repeat (6) stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_ce_n",   {31'd0, bus.bpi_ce_n}, 1);
    checkOutput("arst_oe_n",   {31'd0, bus.bpi_oe_n}, 1);
    checkOutput("arst_adv_n",  {31'd0, bus.bpi_adv_n}, 1);
    checkOutput("arst_tvalid", {31'd0, bus.m_axis_data_tvalid}, 0);
    checkOutput("arst_busy",   {31'd0, bus.busy}, 0);
    applyStimulus(1'b0, '0);
    repeat (2) stepCycle();
    rst = 1'b0;
    repeat (2) stepCycle();
    burstAddr[0] = 26'h100;
    runBurst(1);
    checkOutput("arst_single_cycle", 32'(pulseAt[0]), 13);
    checkOutput("arst_single_data",  32'(pulseData[0]), 32'hBEEF);
    checkOutput("arst_single_idle",  32'(idleAt), 17);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
